// File: rtl/s_axis_window_gen.sv
// KxK sliding-window generator for AXI4-Stream video with inferred line-buffer RAMs.
// Optional macro WINDOW_POS_OUT_EN adds o_col/o_row (position of the newest window pixel).
module s_axis_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int MAX_WIDTH   = 4096,
  parameter int CW          = $clog2(MAX_WIDTH) + 1
) (
  input  logic                                          i_clk,
  input  logic                                          i_aresetn,
  input  logic [CW-1:0]                                 IMAGE_WIDTH,
  input  logic [DATA_WIDTH-1:0]                         s_axis_tdata,
  input  logic                                          s_axis_tvalid,
  input  logic                                          s_axis_tuser,
  input  logic                                          s_axis_tlast,
  output logic                                          s_axis_tready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] o_window,
  output logic                                          o_window_valid,
  output logic                                          o_start_of_frame,
  output logic                                          o_end_of_line,
  input  logic                                          i_ready,
  output logic                                          o_line_err
`ifdef WINDOW_POS_OUT_EN
  ,
  output logic [CW-1:0]                                 o_col,
  output logic [CW-1:0]                                 o_row
`endif
);

  localparam int K  = KERNEL_SIZE;
  localparam int NB = KERNEL_SIZE - 1;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam int WW = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] KM1_C   = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] ROWMX_C = {CW{1'b1}};

  logic stall_s, take_s;
  logic [CW-1:0] eff_col_s, eff_row_s, eff_w_s;
  logic at_end_s, wrap_s;

  logic [CW-1:0] col_d, col_q, row_d, row_q, width_d, width_q;
  logic sof_seen_d, sof_seen_q, line_err_d, line_err_q;

  logic s1_valid_d, s1_valid_q, s1_ok_d, s1_ok_q;
  logic s1_sof_d, s1_sof_q, s1_eol_d, s1_eol_q;
  logic [DATA_WIDTH-1:0] s1_pix_d, s1_pix_q;
  logic [AW-1:0] s1_addr_d, s1_addr_q;

  logic [WW-1:0] win_d, win_q;
  logic win_valid_d, win_valid_q, sof_d, sof_q, eol_d, eol_q;

  logic [NB*DATA_WIDTH-1:0] rd_s;
  logic [K*DATA_WIDTH-1:0]  new_col_s;
  logic wr_en_s;

`ifdef WINDOW_POS_OUT_EN
  logic [CW-1:0] s1_col_d, s1_col_q, s1_row_d, s1_row_q;
  logic [CW-1:0] pos_col_d, pos_col_q, pos_row_d, pos_row_q;
`endif

  // A full output register that downstream refuses freezes the whole pipeline.
  assign stall_s       = win_valid_q & ~i_ready;
  assign s_axis_tready = ~stall_s;
  assign take_s        = s_axis_tvalid & ~stall_s & (sof_seen_q | s_axis_tuser);
  assign wr_en_s       = ~stall_s & s1_valid_q;
  assign new_col_s     = {rd_s, s1_pix_q};

  // Line buffers: buffer b feeds buffer b+1 at the same address, so each adds one line of delay.
  for (genvar b = 0; b < NB; b++) begin : g_line_buf
    logic [DATA_WIDTH-1:0] mem [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] wr_data_s;
    if (b == 0) begin : g_head
      assign wr_data_s = s1_pix_q;
    end else begin : g_chain
      assign wr_data_s = rd_s[(b-1)*DATA_WIDTH +: DATA_WIDTH];
    end
    // Read-before-write RAM port pair, both gated by the stall.
    always_ff @(posedge i_clk) begin
      if (take_s) begin
        rd_data_q <= mem[eff_col_s[AW-1:0]];
      end
      if (wr_en_s) begin
        mem[s1_addr_q] <= wr_data_s;
      end
    end
    assign rd_s[b*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
  end

  // Input side: position tracking, line checking and stage-1 capture.
  always_comb begin
    if (s_axis_tuser) begin
      eff_col_s = '0;
      eff_row_s = '0;
      eff_w_s   = IMAGE_WIDTH;
    end else begin
      eff_col_s = col_q;
      eff_row_s = row_q;
      eff_w_s   = width_q;
    end
    at_end_s = (eff_col_s == (eff_w_s - ONE_C));
    wrap_s   = s_axis_tlast | at_end_s;

    col_d      = col_q;
    row_d      = row_q;
    width_d    = width_q;
    sof_seen_d = sof_seen_q;
    line_err_d = line_err_q;
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_addr_d  = s1_addr_q;
    s1_ok_d    = s1_ok_q;
    s1_sof_d   = s1_sof_q;
    s1_eol_d   = s1_eol_q;
`ifdef WINDOW_POS_OUT_EN
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
`endif

    if (take_s) begin
      sof_seen_d = 1'b1;
      width_d    = eff_w_s;
      if (wrap_s) begin
        col_d = '0;
        if (eff_row_s == ROWMX_C) begin
          row_d = ROWMX_C;
        end else begin
          row_d = eff_row_s + ONE_C;
        end
      end else begin
        col_d = eff_col_s + ONE_C;
        row_d = eff_row_s;
      end
      if (s_axis_tuser) begin
        line_err_d = (s_axis_tlast != at_end_s);
      end else begin
        line_err_d = line_err_q | (s_axis_tlast != at_end_s);
      end
      s1_pix_d  = s_axis_tdata;
      s1_addr_d = eff_col_s[AW-1:0];
      s1_ok_d   = (eff_row_s >= KM1_C) && (eff_col_s >= KM1_C);
      s1_sof_d  = (eff_row_s == KM1_C) && (eff_col_s == KM1_C);
      s1_eol_d  = wrap_s;
`ifdef WINDOW_POS_OUT_EN
      s1_col_d  = eff_col_s;
      s1_row_d  = eff_row_s;
`endif
    end else begin
      sof_seen_d = sof_seen_q;
    end

    if (stall_s) begin
      s1_valid_d = s1_valid_q;
    end else begin
      s1_valid_d = take_s;
    end
  end

  // Output side: shift the new column in; window columns age towards index K-1.
  always_comb begin
    win_d       = win_q;
    win_valid_d = win_valid_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
`ifdef WINDOW_POS_OUT_EN
    pos_col_d   = pos_col_q;
    pos_row_d   = pos_row_q;
`endif
    if (!stall_s) begin
      win_valid_d = s1_valid_q & s1_ok_q;
      sof_d       = s1_valid_q & s1_ok_q & s1_sof_q;
      eol_d       = s1_valid_q & s1_ok_q & s1_eol_q;
      if (s1_valid_q) begin
        for (int r = 0; r < K; r++) begin
          for (int c = K - 1; c > 0; c--) begin
            win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[(r*K+c-1)*DATA_WIDTH +: DATA_WIDTH];
          end
          win_d[(r*K)*DATA_WIDTH +: DATA_WIDTH] = new_col_s[r*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef WINDOW_POS_OUT_EN
        pos_col_d = s1_col_q;
        pos_row_d = s1_row_q;
`endif
      end else begin
        win_d = win_q;
      end
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      sof_seen_q  <= 1'b0;
      line_err_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_addr_q   <= '0;
      s1_ok_q     <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
`ifdef WINDOW_POS_OUT_EN
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      pos_col_q   <= '0;
      pos_row_q   <= '0;
`endif
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      sof_seen_q  <= sof_seen_d;
      line_err_q  <= line_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_addr_q   <= s1_addr_d;
      s1_ok_q     <= s1_ok_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
`ifdef WINDOW_POS_OUT_EN
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      pos_col_q   <= pos_col_d;
      pos_row_q   <= pos_row_d;
`endif
    end
  end

  assign o_window         = win_q;
  assign o_window_valid   = win_valid_q;
  assign o_start_of_frame = sof_q;
  assign o_end_of_line    = eol_q;
  assign o_line_err       = line_err_q;
`ifdef WINDOW_POS_OUT_EN
  assign o_col            = pos_col_q;
  assign o_row            = pos_row_q;
`endif

endmodule

// File: tb/tb_s_axis_window_gen.sv
// Scoreboard bench for s_axis_window_gen: a 2-D image model predicts every window,
// a monitor pops and compares whenever a window is handed downstream.
module tb_s_axis_window_gen;
  localparam int DW = 8;
  localparam int K  = 5;
  localparam int MW = 4096;
  localparam int CW = 13;
  localparam int WW = K * K * DW;

  logic clk = 1'b0;
  logic rst_n;
  logic [CW-1:0] img_width;
  logic [DW-1:0] tdata;
  logic tvalid, tuser, tlast, tready;
  logic [WW-1:0] o_window;
  logic o_window_valid, o_start_of_frame, o_end_of_line, i_ready, o_line_err;
`ifdef WINDOW_POS_OUT_EN
  logic [CW-1:0] o_col, o_row;
`endif

  s_axis_window_gen #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_WIDTH(MW), .CW(CW)) dut (
    .i_clk(clk), .i_aresetn(rst_n), .IMAGE_WIDTH(img_width),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tready(tready),
    .o_window(o_window), .o_window_valid(o_window_valid),
    .o_start_of_frame(o_start_of_frame), .o_end_of_line(o_end_of_line),
    .i_ready(i_ready), .o_line_err(o_line_err)
`ifdef WINDOW_POS_OUT_EN
    , .o_col(o_col), .o_row(o_row)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0]  win;
    logic [K*K-1:0] mask;
    bit sof;
    bit eol;
    int col;
    int row;
    int cyc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0, n_win = 0, cyc = 0;
  bit rdy_rand = 1'b0;

  // Reference image of the current frame, indexed [row][col].
  logic [DW-1:0] img [32][32];
  bit img_v [32][32];
  bit m_seen = 1'b0, m_err = 1'b0;
  int m_col = 0, m_row = 0, m_w = 0;

  task automatic chk(input string name, input longint got, input longint expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit u, input bit l);
    bit hit;
    exp_t e;
    if (u) begin
      m_seen = 1'b1; m_col = 0; m_row = 0; m_w = int'(img_width); m_err = 1'b0;
      for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) img_v[r][c] = 1'b0;
    end
    if (!m_seen) return;
    hit = (m_col == m_w - 1);
    if (l != hit) m_err = 1'b1;
    img[m_row][m_col] = d;
    img_v[m_row][m_col] = 1'b1;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      e.win = '0; e.mask = '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          bit ok;
          ok = 1'b1;
          // A line buffer entry is exact only if every intermediate line reached this column.
          for (int k = 0; k <= r; k++) if (!img_v[m_row-k][m_col-c]) ok = 1'b0;
          e.mask[r*K+c] = ok;
          if (ok) e.win[(r*K+c)*DW +: DW] = img[m_row-r][m_col-c];
        end
      end
      e.sof = (m_row == K - 1) && (m_col == K - 1);
      e.eol = l || hit;
      e.col = m_col; e.row = m_row; e.cyc = cyc; e.lat = !rdy_rand;
      exp_q.push_back(e);
    end
    if (l || hit) begin m_col = 0; m_row++; end else m_col++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit u, input bit l);
    bit acc;
    int guard;
    guard = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = tready;
      if (acc) model_beat(d, u, l);
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) chk("beat_accept_timeout", 0, 1);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input int w, input int lines, input int short_row,
                            input int short_len, input bit ramp, input bit gaps);
    int len;
    logic [DW-1:0] d;
    img_width = CW'(w);
    for (int r = 0; r < lines; r++) begin
      len = (r == short_row) ? short_len : w;
      for (int c = 0; c < len; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        d = ramp ? DW'(r * 16 + c) : DW'($urandom);
        send_beat(d, (r == 0 && c == 0), (c == len - 1));
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic reset_outputs_check();
    @(negedge clk);
    chk("rst_window_zero", (o_window == '0), 1);
    chk("rst_valid", o_window_valid, 0);
    chk("rst_sof", o_start_of_frame, 0);
    chk("rst_eol", o_end_of_line, 0);
    chk("rst_line_err", o_line_err, 0);
    chk("rst_tready", tready, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: held high unless the random-backpressure phase is active.
  initial forever begin
    @(posedge clk); #1;
    i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: each window handed downstream (valid & ready) is popped and compared once.
  initial forever begin
    exp_t e;
    bit bad;
    @(negedge clk);
    if (rst_n) begin
      chk("tready_rule", tready, !(o_window_valid && !i_ready));
      if (o_window_valid && i_ready) begin
        n_win++;
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          bad = 1'b0;
          for (int i = 0; i < K * K; i++)
            if (e.mask[i] && o_window[i*DW +: DW] !== e.win[i*DW +: DW]) bad = 1'b1;
          n_cmp++;
          if (bad) begin
            n_fail++;
            $display("FAIL window r%0d c%0d: got %h expected %h mask %h",
                     e.row, e.col, o_window, e.win, e.mask);
          end
          chk("start_of_frame", o_start_of_frame, e.sof);
          chk("end_of_line", o_end_of_line, e.eol);
          if (e.lat) chk("latency_cycles", cyc - e.cyc, 2);
`ifdef WINDOW_POS_OUT_EN
          chk("o_col", o_col, e.col);
          chk("o_row", o_row, e.row);
`endif
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
    img_width = CW'(16); i_ready = 1'b1;
    repeat (3) @(posedge clk);
    reset_outputs_check();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: partial frame, reset mid-line, then beats before SOF are dropped.
    send_frame(16, 6, -1, 0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) send_beat(DW'($urandom), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_seen = 1'b0;
    reset_outputs_check();
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = n_win;
    for (int i = 0; i < 40; i++) send_beat(DW'($urandom), 1'b0, (i % 16) == 15);
    drain();
    chk("pre_sof_windows", n_win - w0, 0);

    // T2: ramp frame with downstream always ready.
    w0 = n_win;
    send_frame(16, 8, -1, 0, 1'b1, 1'b0);
    drain();
    chk("t2_window_count", n_win - w0, 48);
    chk("t2_line_err", o_line_err, m_err);

    // T3: same ramp frame with random backpressure and input gaps.
    rdy_rand = 1'b1;
    w0 = n_win;
    send_frame(16, 8, -1, 0, 1'b1, 1'b1);
    drain();
    rdy_rand = 1'b0;
    drain();
    chk("t3_window_count", n_win - w0, 48);

    // T4: early tlast on column 11 of line 2 sets the sticky error.
    send_frame(16, 8, 2, 12, 1'b0, 1'b1);
    drain();
    chk("t4_line_err_set", o_line_err, m_err);
    chk("t4_line_err_is_one", o_line_err, 1);

    // T5: SOF clears the error, then a narrower frame.
    send_frame(16, 8, -1, 0, 1'b0, 1'b0);
    drain();
    chk("t5_line_err_cleared", o_line_err, 0);
    rdy_rand = 1'b1;
    w0 = n_win;
    send_frame(9, 8, -1, 0, 1'b0, 1'b1);
    drain();
    rdy_rand = 1'b0;
    drain();
    chk("t5_window_count", n_win - w0, 20);
    chk("t5_line_err", o_line_err, m_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
